rider_load_cond: RTL

- Conditions the left and right load-cell readings into the rider-presence and rider-balance flags used by the steering-enable state machine.
- Owns the 1.3 s settle timer that the state machine clears and monitors.
- Sits between the A2D load-cell sampling interface (upstream) and the steering-enable state machine (downstream).
- Two-stage sample pipeline plus a saturating 26-bit timer.

---
 rtl/rider_load_cond_if.sv | 58 +++++
 rtl/rider_load_cond.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/rider_load_cond_if.sv
// -----------------------------------------------------------------------------
// rider_load_cond_if
//
// Purpose:
//   Bundles the load-cell sample bus, the settle-timer control and the
//   conditioned rider flags exchanged between the sampling front end /
//   steering-enable state machine (master) and rider_load_cond (slave).
//
// Signals:
//   lft_ld        12  left load-cell reading, unsigned      (master -> slave)
//   rght_ld       12  right load-cell reading, unsigned     (master -> slave)
//   vld            1  single-cycle strobe, new sample       (master -> slave)
//   clr_tmr        1  synchronous settle-timer clear        (master -> slave)
//   sum_gt_min     1  sum above the upper hysteresis limit  (slave -> master)
//   sum_lt_min     1  sum below the lower hysteresis limit  (slave -> master)
//   diff_gt_eigth  1  |lft-rght| > sum/8                     (slave -> master)
//   diff_gt_15_16  1  |lft-rght| > 15*sum/16                 (slave -> master)
//   tmr_full       1  settle timer saturated                 (slave -> master)
// -----------------------------------------------------------------------------
interface rider_load_cond_if;

    logic [11:0] lft_ld;
    logic [11:0] rght_ld;
    logic        vld;
    logic        clr_tmr;
    logic        sum_gt_min;
    logic        sum_lt_min;
    logic        diff_gt_eigth;
    logic        diff_gt_15_16;
    logic        tmr_full;

    // Upstream sampler / steering state machine side.
    modport master (
        output lft_ld,
        output rght_ld,
        output vld,
        output clr_tmr,
        input  sum_gt_min,
        input  sum_lt_min,
        input  diff_gt_eigth,
        input  diff_gt_15_16,
        input  tmr_full
    );

    // Conditioning block side.
    modport slave (
        input  lft_ld,
        input  rght_ld,
        input  vld,
        input  clr_tmr,
        output sum_gt_min,
        output sum_lt_min,
        output diff_gt_eigth,
        output diff_gt_15_16,
        output tmr_full
    );

endinterface : rider_load_cond_if

// File: rtl/rider_load_cond.sv
// -----------------------------------------------------------------------------
// rider_load_cond
//
// Purpose:
//   Conditions the left/right load-cell readings into rider-presence and
//   rider-balance flags for the steering-enable state machine, and owns the
//   1.3 s settle timer that the state machine clears and monitors.
//
//   Stage 1 registers the sum and absolute difference of a strobed sample.
//   Stage 2 registers all four flags together from the stage-1 values, so a
//   sample strobed in one cycle is reflected on the flags two edges later.
//   The pipeline accepts a new sample every cycle. Flags hold between
//   samples.
//
//   The settle timer is a free-running saturating 26-bit counter, cleared
//   synchronously (level-sensitive) by clr_tmr, independent of the samples.
//
// Ports:
//   clk    1  50 MHz system clock
//   rst    1  asynchronous active-high reset
//   ld_if     rider_load_cond_if.slave
//             inputs : lft_ld[11:0], rght_ld[11:0], vld, clr_tmr
//             outputs: sum_gt_min, sum_lt_min, diff_gt_eigth, diff_gt_15_16,
//                      tmr_full
//
// Parameters:
//   MIN_RIDER_WT  nominal minimum rider weight (sum of both cells)
//   HYSTERESIS    half-width of the hysteresis band around MIN_RIDER_WT
//   TMR_FULL_CNT  settle-timer terminal count (1.3 s at 50 MHz)
// -----------------------------------------------------------------------------
module rider_load_cond #(
    parameter logic [12:0] MIN_RIDER_WT = 13'h0200,
    parameter logic [12:0] HYSTERESIS   = 13'h0040,
    parameter logic [25:0] TMR_FULL_CNT = 26'd65000000
) (
    input  logic                     clk,
    input  logic                     rst,
    rider_load_cond_if.slave         ld_if
);

    // Hysteresis band limits; strict compares leave both limits inside the
    // band, where neither presence flag is set.
    localparam logic [12:0] SUM_HI_LIM = MIN_RIDER_WT + HYSTERESIS;
    localparam logic [12:0] SUM_LO_LIM = MIN_RIDER_WT - HYSTERESIS;

    // -------------------------------------------------------------------------
    // Stage 1: sum and absolute difference
    // -------------------------------------------------------------------------
    logic [12:0] sum_s1_d,  sum_s1_q;
    logic [11:0] diff_s1_d, diff_s1_q;
    logic        v1_q;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        sum_s1_d  = sum_s1_q;
        diff_s1_d = diff_s1_q;
        if (ld_if.vld) begin
            // Zero-extend before adding so the carry lands in bit 12.
            sum_s1_d = {1'b0, ld_if.lft_ld} + {1'b0, ld_if.rght_ld};
            // Compare-then-subtract keeps the magnitude unsigned in 12 bits.
            if (ld_if.lft_ld >= ld_if.rght_ld) begin
                diff_s1_d = ld_if.lft_ld - ld_if.rght_ld;
            end else begin
                diff_s1_d = ld_if.rght_ld - ld_if.lft_ld;
            end
        end
    end

    // NOTE: the pipeline data registers are reset along with the valid bits;
    // they are few and a known value keeps reset state fully deterministic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_s1_q  <= '0;
            diff_s1_q <= '0;
            v1_q      <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge values regardless of statement order.
            sum_s1_q  <= sum_s1_d;
            diff_s1_q <= diff_s1_d;
            v1_q      <= ld_if.vld;
        end
    end

    // -------------------------------------------------------------------------
    // Stage 2: flag decode
    // -------------------------------------------------------------------------
    logic [12:0] sum_eighth;     // sum/8, truncating
    logic [12:0] sum_15_16;      // sum - sum/16, truncating
    logic [12:0] diff_ext;

    logic sum_gt_min_d,    sum_gt_min_q;
    logic sum_lt_min_d,    sum_lt_min_q;
    logic diff_gt_eigth_d, diff_gt_eigth_q;
    logic diff_gt_15_16_d, diff_gt_15_16_q;

    always_comb begin
        sum_eighth = sum_s1_q >> 3;
        sum_15_16  = sum_s1_q - (sum_s1_q >> 4);
        diff_ext   = {1'b0, diff_s1_q};

        // Flags hold unless a valid stage-1 sample is present.
        sum_gt_min_d    = sum_gt_min_q;
        sum_lt_min_d    = sum_lt_min_q;
        diff_gt_eigth_d = diff_gt_eigth_q;
        diff_gt_15_16_d = diff_gt_15_16_q;

        if (v1_q) begin
            sum_gt_min_d    = (sum_s1_q > SUM_HI_LIM);
            sum_lt_min_d    = (sum_s1_q < SUM_LO_LIM);
            // With sum = 0 both thresholds are 0 and diff is 0, so 0 > 0
            // leaves both balance flags clear.
            diff_gt_eigth_d = (diff_ext > sum_eighth);
            diff_gt_15_16_d = (diff_ext > sum_15_16);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // No rider is assumed out of reset.
            sum_gt_min_q    <= 1'b0;
            sum_lt_min_q    <= 1'b1;
            diff_gt_eigth_q <= 1'b0;
            diff_gt_15_16_q <= 1'b0;
        end else begin
            sum_gt_min_q    <= sum_gt_min_d;
            sum_lt_min_q    <= sum_lt_min_d;
            diff_gt_eigth_q <= diff_gt_eigth_d;
            diff_gt_15_16_q <= diff_gt_15_16_d;
        end
    end

    assign ld_if.sum_gt_min    = sum_gt_min_q;
    assign ld_if.sum_lt_min    = sum_lt_min_q;
    assign ld_if.diff_gt_eigth = diff_gt_eigth_q;
    assign ld_if.diff_gt_15_16 = diff_gt_15_16_q;

    // -------------------------------------------------------------------------
    // Settle timer: saturating, clear has priority over increment
    // -------------------------------------------------------------------------
    logic [25:0] tmr_cnt_d, tmr_cnt_q;
    logic        tmr_at_full;

    assign tmr_at_full = (tmr_cnt_q == TMR_FULL_CNT);

    always_comb begin
        tmr_cnt_d = tmr_cnt_q;
        if (ld_if.clr_tmr) begin
            tmr_cnt_d = '0;
        end else if (!tmr_at_full) begin
            tmr_cnt_d = tmr_cnt_q + 26'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmr_cnt_q <= '0;
        end else begin
            tmr_cnt_q <= tmr_cnt_d;
        end
    end

    // Decoded straight from the count register, so it drops on the same edge
    // that a clear takes effect.
    assign ld_if.tmr_full = tmr_at_full;

endmodule : rider_load_cond
